// File: rtl/loopback_rx_err_checker_if.sv
// Loopback RX word stream as delivered by the deframer: one word per valid beat,
// with no backpressure.
interface loopback_rx_err_checker_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/loopback_rx_err_checker.sv
// Locks onto an incrementing-counter loopback stream and counts mismatched words,
// checked words and lock losses for the software error-count register.
module loopback_rx_err_checker #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 8
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    loopback_rx_err_checker_if.slave   rx,
    input  logic                       cnt_rst,
    output logic [31:0]                err_cnt,
    output logic [31:0]                word_cnt,
    output logic [15:0]                lock_loss_cnt,
    output logic                       locked
);

    localparam int unsigned GOOD_W = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT)   : 1;
    localparam int unsigned BAD_W  = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
    localparam logic [GOOD_W-1:0]    GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]     BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] ERR_MAX   = '1;
    localparam logic [15:0]          LOSS_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] exp_q, exp_n;
    logic [GOOD_W-1:0]     good_q, good_n;
    logic [BAD_W-1:0]      bad_q, bad_n;
    logic [CNT_WIDTH-1:0]  err_q, err_n;
    logic [31:0]           word_q, word_n;
    logic [15:0]           loss_q, loss_n;
    logic                  locked_q;

    logic                  match;
    logic                  err_inc;
    logic                  word_inc;
    logic                  loss_inc;
    logic [DATA_WIDTH-1:0] seed_next;
    logic [DATA_WIDTH-1:0] exp_plus1;

    // Counter arithmetic wraps naturally at DATA_WIDTH, so all-ones is followed by zero.
    assign match     = (rx.rx_data == exp_q);
    assign seed_next = rx.rx_data + DATA_WIDTH'(1);
    assign exp_plus1 = exp_q + DATA_WIDTH'(1);

    always_comb begin
        state_n  = state;
        exp_n    = exp_q;
        good_n   = good_q;
        bad_n    = bad_q;
        err_inc  = 1'b0;
        word_inc = 1'b0;
        loss_inc = 1'b0;

        if (rx.rx_valid) begin
            unique case (state)
                IDLE: begin
                    exp_n   = seed_next;
                    good_n  = '0;
                    state_n = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        exp_n = exp_plus1;
                        if (good_q == GOOD_LAST) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end else begin
                            good_n = good_q + GOOD_W'(1);
                        end
                    end else begin
                        exp_n  = seed_next;
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    // Expected value advances even on a miss, so one bad word is one error.
                    word_inc = 1'b1;
                    exp_n    = exp_plus1;
                    if (match) begin
                        bad_n = '0;
                    end else begin
                        err_inc = 1'b1;
                        if (bad_q == BAD_LAST) begin
                            state_n  = IDLE;
                            loss_inc = 1'b1;
                            bad_n    = '0;
                        end else begin
                            bad_n = bad_q + BAD_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Software clear takes priority over any increment in the same cycle.
    always_comb begin
        err_n  = err_q;
        word_n = word_q;
        loss_n = loss_q;
        if (cnt_rst) begin
            err_n  = '0;
            word_n = '0;
            loss_n = '0;
        end else begin
            if (err_inc && (err_q != ERR_MAX)) begin
                err_n = err_q + CNT_WIDTH'(1);
            end
            if (word_inc) begin
                word_n = word_q + 32'd1;
            end
            if (loss_inc && (loss_q != LOSS_MAX)) begin
                loss_n = loss_q + 16'd1;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state    <= IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= '0;
            word_q   <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_n;
            exp_q    <= exp_n;
            good_q   <= good_n;
            bad_q    <= bad_n;
            err_q    <= err_n;
            word_q   <= word_n;
            loss_q   <= loss_n;
            locked_q <= (state_n == LOCKED);
        end
    end

    assign err_cnt       = 32'(err_q);
    assign word_cnt      = word_q;
    assign lock_loss_cnt = loss_q;
    assign locked        = locked_q;

endmodule
